// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/func constants, field ranges, fetch FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mips_pkg;

    // Default fetch address after reset (word-aligned).
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Instruction field bit ranges.
    localparam int OP_MSB       = 31;
    localparam int OP_LSB       = 26;
    localparam int FUNC_MSB     = 5;
    localparam int FUNC_LSB     = 0;
    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    // Primary opcodes, shared with the control decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;

    // Fetch stage states: waiting on memory, or holding an instruction.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } if_state_e;

    function automatic logic [5:0] get_op(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] get_func(input logic [31:0] instr);
        return instr[FUNC_MSB:FUNC_LSB];
    endfunction

    function automatic logic [15:0] get_imm16(input logic [31:0] instr);
        return instr[IMM16_MSB:IMM16_LSB];
    endfunction

    function automatic logic [25:0] get_target26(input logic [31:0] instr);
        return instr[TARGET26_MSB:TARGET26_LSB];
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory fetch bus: request/address out, ack/read-data back.
// Latency: n/a (interface); data is valid in the cycle ack is high.
// Backpressure: requester holds req and addr stable until ack.
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch stage side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_npc_gen.sv
// Combinational next-PC: jump target, taken branch, or sequential pc+4.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result consumed only when the instruction retires.
module npc_gen
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] target26,
    input  logic [15:0] imm16,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] npc
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;

    // Candidate targets; all arithmetic wraps modulo 2^32.
    always_comb begin
        pc4     = pc + 32'd4;
        br_off  = {{14{imm16[15]}}, imm16, 2'b00};
        br_tgt  = pc4 + br_off;
        jmp_tgt = {pc4[31:28], target26, 2'b00};
    end

    // Jump wins over a taken branch.
    always_comb begin
        npc = pc4;
        if (jump) begin
            npc = jmp_tgt;
        end else if (branch && zero) begin
            npc = br_tgt;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Fetch stage: holds PC, fetches one word per instruction, computes next PC on retire.
// Latency: ack at N -> instr_valid at N+1; instr_done at M -> new fetch at M+1 (2-cycle minimum).
// Backpressure: stalls in FETCH until imem_ack, holds instr in EXEC until instr_done. Optional counters: IFETCH_PERF_EN.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    ifetch_if.master    imem,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_done,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc;

    npc_gen u_npc_gen (
        .pc       (pc_q),
        .target26 (get_target26(instr_q)),
        .imm16    (get_imm16(instr_q)),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .npc      (npc)
    );

    // Next-state: capture the word on ack, advance the PC on retire.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (instr_done) begin
                    pc_d    = npc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs are straight copies of registers or decodes of the state.
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ST_EXEC);
    assign instr          = instr_q;
    assign op             = get_op(instr_q);
    assign func           = get_func(instr_q);
    assign pc             = pc_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    // Count retirements and fetch cycles still waiting on memory.
    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (state_q == ST_EXEC && instr_done) begin
            retired_d = retired_q + 32'd1;
        end
        if (state_q == ST_FETCH && !imem.imem_ack) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_retired = retired_q;
    assign perf_stall   = stall_q;
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed vector table, randomized transactions, reset corners.
// Latency: n/a.
// Backpressure: memory ack and retire delays varied per instruction.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_done;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;

    ifetch_if bus ();

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus),
        .instr        (instr),
        .op           (op),
        .func         (func),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .instr_done   (instr_done),
        .branch       (branch),
        .jump         (jump),
        .zero         (zero),
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_stall;

    typedef struct {
        logic [31:0] word;
        int          ack_dly;
        int          done_dly;
        logic        br;
        logic        jp;
        logic        zr;
        logic [31:0] exp_pc;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef IFETCH_PERF_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] w,
                                            input logic br, input logic jp, input logic zr);
        logic [31:0] p4;
        int          imm;
        p4 = p + 32'd4;
        if (jp) begin
            return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        end
        if (br && zr) begin
            imm = int'(w & 32'h0000_FFFF);
            if (imm >= 32768) imm = imm - 65536;
            return p4 + 32'(imm * 4);
        end
        return p4;
    endfunction

    task automatic noise_ctl();
        branch = 1'($urandom_range(0, 1));
        jump   = 1'($urandom_range(0, 1));
        zero   = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_ret   = 32'd0;
        m_stall = 32'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},     32'(bus.imem_req), 32'd1);
        check({tag, "_valid"},   32'(instr_valid), 32'd0);
        check({tag, "_addr"},    bus.imem_addr, RST_PC);
        check({tag, "_pc"},      pc, RST_PC);
        check({tag, "_instr"},   instr, 32'd0);
        check({tag, "_retired"}, perf_retired, 32'd0);
        check({tag, "_stall"},   perf_stall, 32'd0);
    endtask

    // One full instruction: ad cycles of fetch stall, ack, dd cycles in EXEC, retire.
    task automatic run_instr(input logic [31:0] w, input int ad, input int dd,
                             input logic br, input logic jp, input logic zr);
        for (int k = 0; k < ad; k++) begin
            check("stall_req",   32'(bus.imem_req), 32'd1);
            check("stall_addr",  bus.imem_addr, m_pc);
            check("stall_valid", 32'(instr_valid), 32'd0);
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            instr_done     = 1'($urandom_range(0, 1));
            noise_ctl();
            tick();
            m_stall = m_stall + 32'd1;
        end
        check("fetch_req",  32'(bus.imem_req), 32'd1);
        check("fetch_addr", bus.imem_addr, m_pc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        instr_done     = 1'($urandom_range(0, 1));
        noise_ctl();
        tick();
        bus.imem_ack = 1'b0;
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_req",   32'(bus.imem_req), 32'd0);
        check("exec_instr", instr, w);
        check("exec_op",    32'(op), w >> 26);
        check("exec_func",  32'(func), w % 64);
        check("exec_pc",    pc, m_pc);
        check("exec_stall", perf_stall, exp_cnt(m_stall));
        for (int k = 0; k < dd; k++) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            instr_done     = 1'b0;
            noise_ctl();
            tick();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, w);
        end
        bus.imem_ack = 1'($urandom_range(0, 1));
        instr_done   = 1'b1;
        branch       = br;
        jump         = jp;
        zero         = zr;
        tick();
        instr_done   = 1'b0;
        bus.imem_ack = 1'b0;
        m_pc  = ref_npc(m_pc, w, br, jp, zr);
        m_ret = m_ret + 32'd1;
        check("done_req",     32'(bus.imem_req), 32'd1);
        check("done_valid",   32'(instr_valid), 32'd0);
        check("done_addr",    bus.imem_addr, m_pc);
        check("done_retired", perf_retired, exp_cnt(m_ret));
        check("done_stall",   perf_stall, exp_cnt(m_stall));
    endtask

    initial begin
        // word, ack_dly, done_dly, br, jp, zr, pc of word, next fetch address
        vecs[0] = '{32'h1022_FFFF, 5, 0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000};
        vecs[1] = '{32'h1022_FFFF, 0, 2, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3004};
        vecs[2] = '{32'h0022_1821, 1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h0000_3008};
        vecs[3] = '{32'h0800_0C10, 0, 1, 1'b1, 1'b1, 1'b1, 32'h0000_3008, 32'h0000_3040};
        vecs[4] = '{32'h1022_F3EE, 2, 0, 1'b1, 1'b0, 1'b1, 32'h0000_3040, 32'hFFFF_FFFC};
        vecs[5] = '{32'h0022_1821, 0, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[6] = '{32'h1022_FFFE, 1, 1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC};
        vecs[7] = '{32'h0800_0C00, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_3000};

        rst_n          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        instr_done     = 1'b1;
        branch         = 1'b1;
        jump           = 1'b1;
        zero           = 1'b1;
        tick();
        tick();
        rst_n        = 1'b1;
        bus.imem_ack = 1'b0;
        instr_done   = 1'b0;
        model_reset();
        check_reset_state("rst");

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            check("vec_pc", bus.imem_addr, vecs[i].exp_pc);
            run_instr(vecs[i].word, vecs[i].ack_dly, vecs[i].done_dly,
                      vecs[i].br, vecs[i].jp, vecs[i].zr);
            check("vec_npc", bus.imem_addr, vecs[i].exp_npc);
            if (i == 0) check("stall5", perf_stall, exp_cnt(32'd5));
        end

        // Randomized instructions against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        // Reset in EXEC with instr_done high: pc must return to reset value.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0022_1821;
        tick();
        bus.imem_ack = 1'b0;
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst_n      = 1'b0;
        instr_done = 1'b1;
        branch     = 1'b1;
        jump       = 1'b1;
        zero       = 1'b1;
        tick();
        rst_n      = 1'b1;
        instr_done = 1'b0;
        model_reset();
        check_reset_state("rst_exec");

        // Reset in FETCH with ack high: the word must not be captured.
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0800_0C10;
        tick();
        rst_n        = 1'b1;
        bus.imem_ack = 1'b0;
        check_reset_state("rst_fetch");

        // Normal operation resumes after reset.
        run_instr(32'h0022_1821, 1, 0, 1'b0, 1'b0, 1'b0);
        check("resume_addr", bus.imem_addr, 32'h0000_3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
